fifo_word_packer: RTL and testbench

//  - Downstream consumer of the synchronous FIFO (first-word-fall-through read port: read_data valid while !empty, pop on ren).
//  - Pops RATIO consecutive DATA_WIDTH words and emits one packed OUT_WIDTH word on a valid/ready stream.
//  - Sits between the narrow pixel/command FIFO and the wider GPU datapath.
//  - Sustains one pop per cycle while the output stream accepts.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_word_packer.sv | 124 ++++++++++++
 tb/tb_fifo_word_packer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO and its downstream consumers.
//
// Contents:
//   FIFO_DATA_WIDTH - default FIFO word width, shared by the FIFO and the packer
//   pk_state_t      - word-packer state encoding (PK_FILL=1'b0, PK_HOLD=1'b1)
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 4;

  typedef enum logic {
    PK_FILL = 1'b0,  // collecting lanes, out_valid=0
    PK_HOLD = 1'b1   // complete word presented, out_valid=1
  } pk_state_t;

endpackage : fifo_pkg

// File: rtl/fifo_word_packer.sv
// fifo_word_packer
//   Pops RATIO consecutive words from a first-word-fall-through FIFO and
//   presents them as one packed OUT_WIDTH word on a valid/ready stream.
//   The first popped word lands in out_data[DATA_WIDTH-1:0]. While the output
//   stream accepts, the packer sustains one pop per cycle: a word is accepted
//   and the first lane of the next one captured on the same edge.
//
// Configuration macro: PACKER_FLUSH_EN
//   Defined   - adds the flush input and out_count output, so a partially
//               filled word can be emitted with its lane count.
//   Undefined - a word is emitted only when all RATIO lanes are filled.
//
// Ports:
//   clk        in   1          single clock, posedge
//   reset      in   1          synchronous, active-high
//   empty      in   1          FIFO empty flag
//   read_data  in   DATA_WIDTH FIFO head word, valid while empty==0
//   ren        out  1          FIFO pop request (combinational)
//   out_data   out  OUT_WIDTH  packed word
//   out_valid  out  1          out_data holds a complete word
//   out_ready  in   1          downstream accepts when out_valid & out_ready
//   flush      in   1          (PACKER_FLUSH_EN) emit the partial word
//   out_count  out  CNT_WIDTH  (PACKER_FLUSH_EN) valid lanes in out_data
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter  int RATIO      = 4,
  localparam int OUT_WIDTH  = DATA_WIDTH * RATIO,
  localparam int CNT_WIDTH  = $clog2(RATIO + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  ren,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef PACKER_FLUSH_EN
  ,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  out_count
`endif
);

  pk_state_t            state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic [OUT_WIDTH-1:0] data_next;

  // Pop whenever the FIFO has data and there is room: always in FILL, and in
  // HOLD only when the held word leaves on this same edge.
  assign ren = ~reset & ~empty & ((state == PK_FILL) | out_ready);

  assign out_valid = (state == PK_HOLD);

`ifdef PACKER_FLUSH_EN
  // cnt counts filled lanes and reaches RATIO in HOLD for a full word, so it
  // is exactly the lane count of the presented word.
  assign out_count = cnt;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_next = state;
    cnt_next   = cnt;
    data_next  = out_data;

    case (state)
      PK_FILL: begin
        if (ren) begin
          // Lane write-enable decoded from cnt.
          for (int i = 0; i < RATIO; i++) begin
            if (CNT_WIDTH'(i) == cnt)
              data_next[i*DATA_WIDTH +: DATA_WIDTH] = read_data;
          end
          cnt_next = cnt + CNT_WIDTH'(1);
          if (cnt == CNT_WIDTH'(RATIO - 1))
            state_next = PK_HOLD;
        end
`ifdef PACKER_FLUSH_EN
        // A lane captured on the flush cycle itself counts; an empty word
        // is never emitted.
        if (flush && (cnt_next != '0))
          state_next = PK_HOLD;
`endif
      end

      PK_HOLD: begin
        if (out_ready) begin
          // Word leaves; start the next one with all lanes cleared so
          // unfilled lanes read 0 when it is presented.
          state_next = PK_FILL;
          data_next  = '0;
          cnt_next   = '0;
          if (ren) begin
            data_next[DATA_WIDTH-1:0] = read_data;
            cnt_next                  = CNT_WIDTH'(1);
          end
        end
      end

      default: state_next = PK_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state    <= PK_FILL;
      cnt      <= '0;
      // NOTE: the lane registers are reset too, since out_data must read 0
      // after reset and a mid-word reset must discard captured lanes.
      out_data <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      out_data <= data_next;
    end
  end

endmodule : fifo_word_packer

// File: tb/tb_fifo_word_packer.sv
// Directed testbench for fifo_word_packer (DATA_WIDTH=4, RATIO=4).
// A queue stands in for the FIFO: its head drives read_data, its size drives
// empty, and it is popped on every edge where ren was high.
// Flush scenarios are compiled in when PACKER_FLUSH_EN is defined.
module tb_fifo_word_packer;

  localparam int DW  = 4;
  localparam int R   = 4;
  localparam int OW  = DW * R;
  localparam int CW  = $clog2(R + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          empty;
  logic [DW-1:0] read_data;
  logic          ren;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
`ifdef PACKER_FLUSH_EN
  logic          flush;
  logic [CW-1:0] out_count;
`endif

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] fq[$];

  fifo_word_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk       (clk),
    .reset     (reset),
    .empty     (empty),
    .read_data (read_data),
    .ren       (ren),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PACKER_FLUSH_EN
    ,
    .flush     (flush),
    .out_count (out_count)
`endif
  );

  always #5 clk = ~clk;

  // One clock cycle: present the FIFO head, sample ren, take the edge, pop.
  task automatic tick(output logic ren_seen);
    empty     = (fq.size() == 0);
    read_data = (fq.size() == 0) ? '0 : fq[0];
    #1;
    ren_seen = ren;
    @(posedge clk);
    if (ren_seen && fq.size() > 0) void'(fq.pop_front());
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
  endtask

  task automatic do_reset();
    logic r;
    reset = 1'b1;
    fq.delete();
    tick(r);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic r;
    reset     = 1'b1;
    out_ready = 1'b1;
    push(4'h7);
    tick(r);
    total++;
    if (r !== 1'b0) begin
      bad++; $display("FAIL reset_ren: got %b want 0", r);
    end
    tick(r);
    total++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
      bad++; $display("FAIL reset_out: valid=%b data=%h want 0/0000", out_valid, out_data);
    end
`ifdef PACKER_FLUSH_EN
    total++;
    if (out_count !== 3'd0) begin
      bad++; $display("FAIL reset_count: got %0d want 0", out_count);
    end
`endif
    reset = 1'b0;
    fq.delete();
  endtask

  task automatic test_fill();
    logic r;
    int   pops = 0;
    out_ready = 1'b1;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    for (int i = 0; i < 4; i++) begin
      tick(r);
      if (r === 1'b1) pops++;
      if (i < 3) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++; $display("FAIL fill_early_valid: cycle %0d got %b want 0", i, out_valid);
        end
      end
    end
    total++;
    if (pops != 4) begin
      bad++; $display("FAIL fill_pops: got %0d want 4", pops);
    end
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h4321) begin
      bad++; $display("FAIL fill_word: valid=%b data=%h want 1/4321", out_valid, out_data);
    end
    tick(r);
    total++;
    if (out_valid !== 1'b0 || r !== 1'b0) begin
      bad++; $display("FAIL fill_accept: valid=%b ren=%b want 0/0", out_valid, r);
    end
  endtask

  task automatic test_backpressure();
    logic r;
    int   errs = 0;
    out_ready = 1'b0;
    push(4'h5); push(4'h6); push(4'h7); push(4'h8); push(4'h9);
    for (int i = 0; i < 4; i++) tick(r);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h8765) begin
      bad++; $display("FAIL bp_word: valid=%b data=%h want 1/8765", out_valid, out_data);
    end
    for (int i = 0; i < 5; i++) begin
      tick(r);
      if (r !== 1'b0 || out_valid !== 1'b1 || out_data !== 16'h8765) begin
        errs++;
        $display("FAIL bp_hold: cycle %0d ren=%b valid=%b data=%h want 0/1/8765", i, r, out_valid, out_data);
      end
    end
    total++;
    if (errs != 0) bad++;
    out_ready = 1'b1;
    tick(r);
    total++;
    if (r !== 1'b1 || out_valid !== 1'b0 || fq.size() != 0) begin
      bad++; $display("FAIL bp_resume: ren=%b valid=%b left=%0d want 1/0/0", r, out_valid, fq.size());
    end
    do_reset();
  endtask

  task automatic test_streaming();
    logic          r;
    int            ren_lo = 0;
    int            errs   = 0;
    logic [OW-1:0] exp_w[3];
    exp_w[0] = 16'h3210; exp_w[1] = 16'h7654; exp_w[2] = 16'hBA98;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) push(DW'(i));
    for (int i = 1; i <= 12; i++) begin
      tick(r);
      if (r !== 1'b1) ren_lo++;
      if (i % 4 == 0) begin
        if (out_valid !== 1'b1 || out_data !== exp_w[i/4-1]) begin
          errs++;
          $display("FAIL stream_word%0d: valid=%b data=%h want 1/%h", i/4-1, out_valid, out_data, exp_w[i/4-1]);
        end
      end else if (out_valid !== 1'b0) begin
        errs++;
        $display("FAIL stream_bubble: edge %0d valid=%b want 0", i, out_valid);
      end
    end
    total++;
    if (ren_lo != 0) begin
      bad++; $display("FAIL stream_ren: low cycles=%0d want 0", ren_lo);
    end
    total++;
    if (errs != 0) bad++;
    tick(r);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL stream_drain: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_starvation();
    logic r;
    int   errs = 0;
    out_ready = 1'b1;
    push(4'h1); push(4'h2);
    tick(r); tick(r);
    for (int i = 0; i < 10; i++) begin
      tick(r);
      if (r !== 1'b0 || out_valid !== 1'b0) begin
        errs++;
        $display("FAIL starve_idle: cycle %0d ren=%b valid=%b want 0/0", i, r, out_valid);
      end
    end
    total++;
    if (errs != 0) bad++;
    push(4'h3); push(4'h4);
    tick(r);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL starve_third: valid=%b want 0", out_valid);
    end
    tick(r);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h4321) begin
      bad++; $display("FAIL starve_word: valid=%b data=%h want 1/4321", out_valid, out_data);
    end
    tick(r);
  endtask

  task automatic test_reset_mid_word();
    logic r;
    out_ready = 1'b1;
    push(4'h1); push(4'h2); push(4'h3);
    tick(r); tick(r); tick(r);
    do_reset();
    total++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
      bad++; $display("FAIL midrst_out: valid=%b data=%h want 0/0000", out_valid, out_data);
    end
    push(4'hC); push(4'hD); push(4'hE); push(4'hF);
    for (int i = 0; i < 3; i++) tick(r);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_early: valid=%b want 0", out_valid);
    end
    tick(r);
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'hFEDC) begin
      bad++; $display("FAIL midrst_word: valid=%b data=%h want 1/FEDC", out_valid, out_data);
    end
    tick(r);
  endtask

`ifdef PACKER_FLUSH_EN
  task automatic test_flush();
    logic r;
    out_ready = 1'b0;
    flush     = 1'b0;
    push(4'hA); push(4'hB);
    tick(r); tick(r);
    flush = 1'b1;
    tick(r);
    flush = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 16'h00BA || out_count !== 3'd2) begin
      bad++; $display("FAIL flush_word: valid=%b data=%h count=%0d want 1/00BA/2", out_valid, out_data, out_count);
    end
    out_ready = 1'b1;
    tick(r);
    flush = 1'b1;
    tick(r);
    flush = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_empty: valid=%b want 0", out_valid);
    end
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    for (int i = 0; i < 4; i++) tick(r);
    total++;
    if (out_valid !== 1'b1 || out_count !== 3'd4 || out_data !== 16'h4321) begin
      bad++; $display("FAIL flush_full_count: valid=%b count=%0d data=%h want 1/4/4321", out_valid, out_count, out_data);
    end
    tick(r);
  endtask
`endif

  initial begin
    reset     = 1'b1;
    empty     = 1'b1;
    read_data = '0;
    out_ready = 1'b0;
`ifdef PACKER_FLUSH_EN
    flush     = 1'b0;
`endif
    @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_backpressure();
    test_streaming();
    test_starvation();
    test_reset_mid_word();
`ifdef PACKER_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fifo_word_packer
